vx_mem_responder: RTL and testbench
===================================

Name: vx_mem_responder

Overview:
- Memory-side responder for one port of the Vortex socket memory bus.
- Accepts flattened mem_req beats (valid/ready), services them from an internal word-addressed SRAM model, and returns in-order read responses carrying the request tag after a fixed pipeline latency.
- Used as the far end of the socket's L1 memory ports in block-level and top-level benches, and as a small on-chip scratch memory.

Parameters:
- ADDR_WIDTH, 26: word address width of mem_req_addr.
- DATA_SIZE, 64: bytes per beat; data width is DATA_SIZE*8.
- TAG_WIDTH, 8: request/response tag width, uuid included.
- FLAGS_WIDTH, 4: request flags width; flags are accepted and ignored.
- MEM_WORDS, 1024: SRAM depth in beats; power of two.
- LATENCY, 4: cycles from read accept to earliest mem_rsp_valid; must be at least 1.
- RSP_QUEUE_DEPTH, 8: maximum outstanding reads; must be at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- mem_req_valid  in  1  request valid
- mem_req_rw  in  1  1=write, 0=read
- mem_req_addr  in  ADDR_WIDTH  word address
- mem_req_data  in  DATA_SIZE*8  write data
- mem_req_byteen  in  DATA_SIZE  write byte enables
- mem_req_flags  in  FLAGS_WIDTH  ignored
- mem_req_tag  in  TAG_WIDTH  request tag
- mem_req_ready  out  1  request accepted when valid&ready
- mem_rsp_valid  out  1  response valid
- mem_rsp_data  out  DATA_SIZE*8  read data
- mem_rsp_tag  out  TAG_WIDTH  echoed tag
- mem_rsp_ready  in  1  response consumed when valid&ready
- busy  out  1  outstanding reads or queued responses exist

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - mem_rsp_valid=0 and busy=0.
  - The outstanding counter, the latency-pipe valid bits and the queue pointers are cleared.
  - mem_req_ready=1 one cycle after reset deasserts.
  - SRAM contents are not reset.
- Reset mid-operation drops all in-flight reads. No response is issued for them after reset.
- Index: SRAM index is addr[log2(MEM_WORDS)-1:0]. Upper address bits are ignored, so addresses alias.
- Write accept: SRAM bytes with byteen=1 are updated at the accepting edge. No response is generated unless the optional feature is enabled.
- Read accept:
  - SRAM data is sampled at the accepting edge, so later writes do not alter it.
  - Data and tag enter a LATENCY-stage pipe, then a RSP_QUEUE_DEPTH-entry FIFO.
  - A read accepted at edge T is visible on mem_rsp_valid no earlier than cycle T+LATENCY.
- Read-after-write: a read accepted in any cycle after a write's accept returns the written bytes.
- Ordering: responses leave strictly in acceptance order.
- Credit counter:
  - Increments on read accept and decrements on response fire.
  - Simultaneous increment and decrement leaves it unchanged.
  - mem_req_ready = (count < RSP_QUEUE_DEPTH), registered-state only, with no combinational path from mem_req_valid.
  - Writes are accepted whenever mem_req_ready=1.
- Full: at count==RSP_QUEUE_DEPTH, ready=0. Once the queue is full of pending responses, pipe outputs cannot overflow the queue.
- Empty: mem_rsp_valid=0 and the data/tag outputs are don't-care.
- Response stability: while mem_rsp_valid && !mem_rsp_ready, data and tag are held stable.
- Throughput: with mem_rsp_ready held at 1, one read is accepted and one response returned per cycle.
- busy = (count != 0).

Optional Feature:
- Macro: VX_MEM_RSP_WRITE_ACK_EN.
- Defined:
  - Accepted writes also enter the pipe and generate a response with the request tag and data=0.
  - Writes consume credit, are ordered with reads, and gate mem_req_ready like reads.
- Undefined: writes are posted with no response and consume no credit.

Decomposition:
- VX_gpu_pkg holds these packed typedefs:
  - mem_rsp_entry_t {data, tag}.
  - mem_req_beat_t {rw, addr, data, byteen, flags, tag}.
- VX_gpu_pkg holds the constant MEM_RSP_IDX_W = $clog2(MEM_WORDS).
- Sub-module vx_mem_rsp_queue holds the FIFO of mem_rsp_entry_t:
  - Parameter DEPTH.
  - Ports push/pop/full/empty/head.
- The latency pipe and credit counter remain in the top-level module.

Test Plan:
- Reset asserted asynchronously mid-cycle -> mem_rsp_valid=0 and busy=0 immediately; mem_req_ready=1 the cycle after deassert.
- Write addr 0x10 with data 0xA5 repeated and byteen all ones. Then read addr 0x10 with tag 0x3C, LATENCY=4, rsp_ready=1 -> response at accept+4 with data 0xA5 repeated and tag 0x3C.
- Write byteen=0x1 with data 0xFF to addr 0x10 after the step above. Read addr 0x410 (aliases to 0x10 at 1024 words) -> byte0=0xFF, other bytes 0xA5.
- Hold rsp_ready=0 and issue 10 back-to-back reads with tags 0..9 -> exactly 8 accepted, then mem_req_ready=0. Release ready -> tags 0..7 returned in order with stable data while stalled; tags 8 and 9 accepted after credits return.
- Streaming 32 reads with rsp_ready=1 -> one accept per cycle and 32 in-order responses. Toggle rsp_ready at random -> no loss or duplication, and count never exceeds 8.
- With VX_MEM_RSP_WRITE_ACK_EN defined, write tag 0x07 followed by read tag 0x08 -> response tag 0x07 with data 0, then tag 0x08. Without the macro -> only the tag 0x08 response.

Source files
------------

// File: rtl/vx_mem_responder_pkg.sv
// VX_gpu_pkg: shared memory-bus beat/response types and default geometry for vx_mem_responder.
// Struct widths are fixed here, so responder parameters must match these defaults.
package VX_gpu_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 26;
    localparam int unsigned DEF_DATA_SIZE   = 64;
    localparam int unsigned DEF_TAG_WIDTH   = 8;
    localparam int unsigned DEF_FLAGS_WIDTH = 4;
    localparam int unsigned DEF_MEM_WORDS   = 1024;

    localparam int unsigned MEM_RSP_IDX_W = $clog2(DEF_MEM_WORDS);

    typedef struct packed {
        logic [DEF_DATA_SIZE*8-1:0] data;
        logic [DEF_TAG_WIDTH-1:0]   tag;
    } mem_rsp_entry_t;

    typedef struct packed {
        logic                       rw;
        logic [DEF_ADDR_WIDTH-1:0]  addr;
        logic [DEF_DATA_SIZE*8-1:0] data;
        logic [DEF_DATA_SIZE-1:0]   byteen;
        logic [DEF_FLAGS_WIDTH-1:0] flags;
        logic [DEF_TAG_WIDTH-1:0]   tag;
    } mem_req_beat_t;

endpackage

// File: rtl/vx_mem_responder_if.sv
// vx_mem_responder_if: flattened memory-port request/response bundle.
// master drives requests and consumes responses; slave is the memory side.
interface vx_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH  = 26,
    parameter int unsigned DATA_SIZE   = 64,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned FLAGS_WIDTH = 4
);

    logic                   mem_req_valid;
    logic                   mem_req_rw;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic [DATA_SIZE*8-1:0] mem_req_data;
    logic [DATA_SIZE-1:0]   mem_req_byteen;
    logic [FLAGS_WIDTH-1:0] mem_req_flags;
    logic [TAG_WIDTH-1:0]   mem_req_tag;
    logic                   mem_req_ready;

    logic                   mem_rsp_valid;
    logic [DATA_SIZE*8-1:0] mem_rsp_data;
    logic [TAG_WIDTH-1:0]   mem_rsp_tag;
    logic                   mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen,
               mem_req_flags, mem_req_tag, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen,
               mem_req_flags, mem_req_tag, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );

endinterface

// File: rtl/vx_mem_rsp_queue.sv
// vx_mem_rsp_queue: DEPTH-entry FIFO of mem_rsp_entry_t; head is valid whenever !empty.
// Pushes while full and pops while empty are ignored.
module vx_mem_rsp_queue
    import VX_gpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  mem_rsp_entry_t push_entry,
    input  logic           pop,
    output logic           full,
    output logic           empty,
    output mem_rsp_entry_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    mem_rsp_entry_t   store_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = store_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/vx_mem_responder.sv
// vx_mem_responder: word-addressed SRAM responder with fixed-latency, in-order read responses.
// Define VX_MEM_RSP_WRITE_ACK_EN to make writes return a zero-data response in order with reads.
module vx_mem_responder
    import VX_gpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_SIZE       = DEF_DATA_SIZE,
    parameter int unsigned TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter int unsigned FLAGS_WIDTH     = DEF_FLAGS_WIDTH,
    parameter int unsigned MEM_WORDS       = DEF_MEM_WORDS,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned RSP_QUEUE_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    vx_mem_responder_if.slave mem,
    output logic              busy
);

    localparam int unsigned DATA_W = DATA_SIZE * 8;
    localparam int unsigned CNT_W  = $clog2(RSP_QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(RSP_QUEUE_DEPTH);

    if (ADDR_WIDTH != DEF_ADDR_WIDTH || DATA_SIZE != DEF_DATA_SIZE ||
        TAG_WIDTH != DEF_TAG_WIDTH || FLAGS_WIDTH != DEF_FLAGS_WIDTH ||
        MEM_WORDS != DEF_MEM_WORDS || LATENCY < 1 || RSP_QUEUE_DEPTH < 2) begin : g_cfg_check
        $error("vx_mem_responder: parameters disagree with VX_gpu_pkg geometry");
    end

    mem_req_beat_t  req;
    mem_rsp_entry_t pipe_in;
    mem_rsp_entry_t q_head;
    logic           ready_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic           req_fire;
    logic           rsp_req;
    logic           rsp_fire;
    logic           q_full;
    logic           q_empty;
    logic           unused_bits;

    assign req = '{
        rw:     mem.mem_req_rw,
        addr:   mem.mem_req_addr,
        data:   mem.mem_req_data,
        byteen: mem.mem_req_byteen,
        flags:  mem.mem_req_flags,
        tag:    mem.mem_req_tag
    };

    assign req_fire = mem.mem_req_valid & ready_q;
`ifdef VX_MEM_RSP_WRITE_ACK_EN
    assign rsp_req = req_fire;
`else
    assign rsp_req = req_fire & ~req.rw;
`endif

    // Upper address bits alias onto the SRAM index.
    logic [MEM_RSP_IDX_W-1:0] idx;
    logic [DATA_W-1:0]        sram_q [MEM_WORDS];

    assign idx         = req.addr[MEM_RSP_IDX_W-1:0];
    assign unused_bits = ^{req.flags, req.addr[ADDR_WIDTH-1:MEM_RSP_IDX_W], q_full};

    always_ff @(posedge clk) begin
        if (req_fire && req.rw) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (req.byteen[b]) sram_q[idx][b*8 +: 8] <= req.data[b*8 +: 8];
            end
        end
    end

    assign pipe_in.data = req.rw ? '0 : sram_q[idx];
    assign pipe_in.tag  = req.tag;

    logic [LATENCY-1:0] pipe_valid_q;
    mem_rsp_entry_t     pipe_q [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_q <= '0;
        end else begin
            pipe_valid_q[0] <= rsp_req;
            for (int i = 1; i < LATENCY; i++) pipe_valid_q[i] <= pipe_valid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_q[0] <= pipe_in;
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end

    // Credits cover pipe plus queue, so the queue never sees a push while full.
    vx_mem_rsp_queue #(
        .DEPTH(RSP_QUEUE_DEPTH)
    ) u_rsp_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_valid_q[LATENCY-1]),
        .push_entry(pipe_q[LATENCY-1]),
        .pop       (rsp_fire),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head)
    );

    assign rsp_fire          = ~q_empty & mem.mem_rsp_ready;
    assign mem.mem_rsp_valid = ~q_empty;
    assign mem.mem_rsp_data  = q_head.data;
    assign mem.mem_rsp_tag   = q_head.tag;
    assign mem.mem_req_ready = ready_q;
    assign busy              = (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (rsp_req && !rsp_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!rsp_req && rsp_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d < MAX_CNT);
        end
    end

endmodule

// File: tb/tb_vx_mem_responder.sv
// tb_vx_mem_responder: directed self-checking bench for vx_mem_responder (default geometry).
module tb_vx_mem_responder;

    localparam int DW = 512;
    localparam int CW = DW + 16;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    vx_mem_responder_if #(
        .ADDR_WIDTH(26), .DATA_SIZE(64), .TAG_WIDTH(8), .FLAGS_WIDTH(4)
    ) mem_bus ();

    vx_mem_responder #(
        .ADDR_WIDTH(26), .DATA_SIZE(64), .TAG_WIDTH(8), .FLAGS_WIDTH(4),
        .MEM_WORDS(1024), .LATENCY(4), .RSP_QUEUE_DEPTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mem  (mem_bus),
        .busy (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        return {64{b}};
    endfunction

    // Response log: edge after which each response was first seen, and its accept edge.
    int edge_n = 0;
    always @(posedge clk) edge_n++;

    logic [DW-1:0] rsp_data_q[$];
    logic [7:0]    rsp_tag_q[$];
    int            rsp_edge_q[$];
    int            acc_edge_q[$];
    int            n_acc = 0;
    int            n_rsp = 0;
    bit            track_credit = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW+7:0] prev_rsp;
    logic          gen_rsp;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("rsp_stable",
                      CW'({mem_bus.mem_rsp_valid, mem_bus.mem_rsp_tag, mem_bus.mem_rsp_data}),
                      CW'({1'b1, prev_rsp}));
`ifdef VX_MEM_RSP_WRITE_ACK_EN
            gen_rsp = 1'b1;
`else
            gen_rsp = ~mem_bus.mem_req_rw;
`endif
            if (mem_bus.mem_req_valid && mem_bus.mem_req_ready && gen_rsp) begin
                acc_edge_q.push_back(edge_n + 1);
                n_acc++;
            end
            if (mem_bus.mem_rsp_valid && mem_bus.mem_rsp_ready) begin
                rsp_data_q.push_back(mem_bus.mem_rsp_data);
                rsp_tag_q.push_back(mem_bus.mem_rsp_tag);
                rsp_edge_q.push_back(edge_n);
                n_rsp++;
            end
            if (track_credit) check("credit_max", CW'((n_acc - n_rsp) <= 8), CW'(1));
            prev_stall = mem_bus.mem_rsp_valid && !mem_bus.mem_rsp_ready;
            prev_rsp   = {mem_bus.mem_rsp_tag, mem_bus.mem_rsp_data};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rsp_data_q.delete();
        rsp_tag_q.delete();
        rsp_edge_q.delete();
        acc_edge_q.delete();
        n_acc = 0;
        n_rsp = 0;
    endtask

    task automatic send(input logic rw, input logic [25:0] addr, input logic [DW-1:0] data,
                        input logic [63:0] be, input logic [7:0] tag);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        mem_bus.mem_req_valid  = 1'b1;
        mem_bus.mem_req_rw     = rw;
        mem_bus.mem_req_addr   = addr;
        mem_bus.mem_req_data   = data;
        mem_bus.mem_req_byteen = be;
        mem_bus.mem_req_tag    = tag;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = mem_bus.mem_req_ready;
            step();
            n++;
        end
        mem_bus.mem_req_valid = 1'b0;
        if (!acc) check("req_timeout", CW'(0), CW'(1));
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_tag_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check("rsp_count", CW'(rsp_tag_q.size()), CW'(n));
    endtask

    task automatic drain();
        int k;
        k = 0;
        mem_bus.mem_rsp_ready = 1'b1;
        while (busy && k < 200) begin
            step();
            k++;
        end
        if (busy) check("drain_timeout", CW'(busy), CW'(0));
        repeat (2) step();
        clear_log();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int   cur;
    int   cycles;
    logic acc;
    bit   done;

    initial begin
        reset                  = 1'b1;
        mem_bus.mem_req_valid  = 1'b0;
        mem_bus.mem_req_rw     = 1'b0;
        mem_bus.mem_req_addr   = '0;
        mem_bus.mem_req_data   = '0;
        mem_bus.mem_req_byteen = '0;
        mem_bus.mem_req_flags  = 4'h5;
        mem_bus.mem_req_tag    = '0;
        mem_bus.mem_rsp_ready  = 1'b1;
        #2;
        check("reset_rsp_valid", CW'(mem_bus.mem_rsp_valid), CW'(0));
        check("reset_busy", CW'(busy), CW'(0));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();
        check("ready_after_reset", CW'(mem_bus.mem_req_ready), CW'(1));

        // Full-word write, preload pattern words, then read-after-write with latency.
        send(1'b1, 26'h10, pat(8'hA5), '1, 8'h01);
        for (int a = 'h20; a < 'h40; a++) send(1'b1, 26'(a), pat(8'(a)), '1, 8'h02);
        drain();
        send(1'b0, 26'h10, '0, '0, 8'h3C);
        wait_rsp(1, 50);
        if (rsp_tag_q.size() > 0 && acc_edge_q.size() > 0) begin
            check("raw_data", CW'(rsp_data_q[0]), CW'(pat(8'hA5)));
            check("raw_tag", CW'(rsp_tag_q[0]), CW'(8'h3C));
            check("raw_latency", CW'(rsp_edge_q[0] - acc_edge_q[0]), CW'(4));
        end
        drain();

        // Partial byte write, then read through an aliased address.
        send(1'b1, 26'h10, pat(8'hFF), 64'h1, 8'h03);
        drain();
        send(1'b0, 26'h410, '0, '0, 8'h3D);
        wait_rsp(1, 50);
        if (rsp_tag_q.size() > 0) begin
            check("alias_data", CW'(rsp_data_q[0]), CW'({{63{8'hA5}}, 8'hFF}));
            check("alias_tag", CW'(rsp_tag_q[0]), CW'(8'h3D));
        end
        drain();

        // Reset with reads in flight: outputs clear at once, nothing comes out afterwards.
        for (int i = 0; i < 3; i++) send(1'b0, 26'(32'h20 + i), '0, '0, 8'(8'h50 + i));
        check("busy_inflight", CW'(busy), CW'(1));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midreset_rsp_valid", CW'(mem_bus.mem_rsp_valid), CW'(0));
        check("midreset_busy", CW'(busy), CW'(0));
        clear_log();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();
        check("ready_after_midreset", CW'(mem_bus.mem_req_ready), CW'(1));
        repeat (10) step();
        check("no_rsp_after_reset", CW'(rsp_tag_q.size()), CW'(0));
        check("idle_after_reset", CW'(busy), CW'(0));

        // Backpressure: 10 reads against a stalled consumer, only 8 credits.
        mem_bus.mem_rsp_ready = 1'b0;
        mem_bus.mem_req_rw    = 1'b0;
        cur = 0;
        for (int c = 0; c < 12; c++) begin
            mem_bus.mem_req_valid = (cur < 10);
            mem_bus.mem_req_addr  = 26'(32'h20 + cur);
            mem_bus.mem_req_tag   = 8'(cur);
            @(negedge clk);
            acc = mem_bus.mem_req_ready;
            step();
            if (acc) cur++;
        end
        mem_bus.mem_req_valid = 1'b0;
        check("bp_accepted", CW'(cur), CW'(8));
        check("bp_ready_low", CW'(mem_bus.mem_req_ready), CW'(0));
        check("bp_rsp_valid", CW'(mem_bus.mem_rsp_valid), CW'(1));
        mem_bus.mem_rsp_ready = 1'b1;
        for (int c = 0; c < 60 && cur < 10; c++) begin
            mem_bus.mem_req_valid = 1'b1;
            mem_bus.mem_req_addr  = 26'(32'h20 + cur);
            mem_bus.mem_req_tag   = 8'(cur);
            @(negedge clk);
            acc = mem_bus.mem_req_ready;
            step();
            if (acc) cur++;
        end
        mem_bus.mem_req_valid = 1'b0;
        check("bp_late_accepts", CW'(cur), CW'(10));
        wait_rsp(10, 100);
        for (int i = 0; i < 10 && i < rsp_tag_q.size(); i++) begin
            check("bp_tag", CW'(rsp_tag_q[i]), CW'(8'(i)));
            check("bp_data", CW'(rsp_data_q[i]), CW'(pat(8'(32'h20 + i))));
        end
        drain();

        // Streaming with the consumer always ready: one accept per cycle.
        cur    = 0;
        cycles = 0;
        while (cur < 32 && cycles < 64) begin
            mem_bus.mem_req_valid = 1'b1;
            mem_bus.mem_req_addr  = 26'(32'h20 + cur);
            mem_bus.mem_req_tag   = 8'(cur);
            @(negedge clk);
            acc = mem_bus.mem_req_ready;
            step();
            cycles++;
            if (acc) cur++;
        end
        mem_bus.mem_req_valid = 1'b0;
        check("stream_accepts", CW'(cur), CW'(32));
        check("stream_cycles", CW'(cycles), CW'(32));
        wait_rsp(32, 100);
        for (int i = 0; i < 32 && i < rsp_tag_q.size(); i++) begin
            check("stream_tag", CW'(rsp_tag_q[i]), CW'(8'(i)));
            check("stream_data", CW'(rsp_data_q[i]), CW'(pat(8'(32'h20 + i))));
        end
        drain();

        // Random consumer stalls: no loss, no duplication, credit bound held.
        track_credit = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) send(1'b0, 26'(32'h20 + i), '0, '0, 8'(8'h80 + i));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    mem_bus.mem_rsp_ready = 1'($urandom_range(0, 1));
                    step();
                end
                mem_bus.mem_rsp_ready = 1'b1;
            end
        join
        wait_rsp(24, 400);
        for (int i = 0; i < 24 && i < rsp_tag_q.size(); i++) begin
            check("rand_tag", CW'(rsp_tag_q[i]), CW'(8'(8'h80 + i)));
            check("rand_data", CW'(rsp_data_q[i]), CW'(pat(8'(32'h20 + i))));
        end
        track_credit = 1'b0;
        drain();

        // Write followed by read: write response only with the acknowledge option.
        send(1'b1, 26'h50, pat(8'h77), '1, 8'h07);
        send(1'b0, 26'h50, '0, '0, 8'h08);
`ifdef VX_MEM_RSP_WRITE_ACK_EN
        wait_rsp(2, 50);
        repeat (10) step();
        check("ack_rsp_total", CW'(rsp_tag_q.size()), CW'(2));
        if (rsp_tag_q.size() >= 2) begin
            check("ack_wr_tag", CW'(rsp_tag_q[0]), CW'(8'h07));
            check("ack_wr_data", CW'(rsp_data_q[0]), CW'(0));
            check("ack_rd_tag", CW'(rsp_tag_q[1]), CW'(8'h08));
            check("ack_rd_data", CW'(rsp_data_q[1]), CW'(pat(8'h77)));
        end
`else
        wait_rsp(1, 50);
        repeat (10) step();
        check("ack_rsp_total", CW'(rsp_tag_q.size()), CW'(1));
        if (rsp_tag_q.size() >= 1) begin
            check("ack_rd_tag", CW'(rsp_tag_q[0]), CW'(8'h08));
            check("ack_rd_data", CW'(rsp_data_q[0]), CW'(pat(8'h77)));
        end
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
